sram_responder: RTL and testbench

- Memory-side responder for the LC-3 datapath's active-low SRAM strobes: CE_N, OE_N, WE_N, UB_N, LB_N.
- Holds a synchronous word-addressed on-chip memory plus two memory-mapped I/O locations: switches (read) and hex display (write).
- Sits between the CPU memory interface (MAR/MDR, Mem_* strobes) and board I/O.
- Timed to the controller's two-cycle strobe windows:
  - read data is valid in the second OE_N-low cycle;
  - each WE_N-low episode commits exactly once.

---
 rtl/sram_responder.sv | 124 ++++++++++++
 tb/tb_sram_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Memory-side responder for active-low SRAM strobes: word-addressed on-chip RAM plus a switch/hex I/O register.
// Define SRAM_RESPONDER_STATS_EN to add Read_Count / Write_Count outputs.
module sram_responder #(
    parameter int          ADDR_W  = 10,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    input  logic        CE_N,
    input  logic        OE_N,
    input  logic        WE_N,
    input  logic        UB_N,
    input  logic        LB_N,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic [15:0] Hex_Out,
    output logic        Conflict
`ifdef SRAM_RESPONDER_STATS_EN
    ,
    output logic [15:0] Read_Count,
    output logic [15:0] Write_Count
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, RD, WR_HOLD} state_t;

    state_t state_reg, state_next;

    logic              we, oe, ram_hit, io_hit;
    logic              commit, do_read, read_entry;
    logic [1:0]        lane_en;
    logic [15:0]       lane_mask, ram_rd, rd_src;
    logic [ADDR_W-1:0] idx;

    assign we        = ~CE_N & ~WE_N;
    assign oe        = ~CE_N & ~OE_N;
    assign ram_hit   = (ADDR[15:ADDR_W] == '0);
    assign io_hit    = (ADDR == IO_ADDR);
    assign idx       = ADDR[ADDR_W-1:0];
    assign lane_en   = {~UB_N, ~LB_N};
    assign lane_mask = {{8{lane_en[1]}}, {8{lane_en[0]}}};

    // Writes commit only on the edge that enters WR_HOLD; a held WE_N is ignored.
    always_comb begin
        state_next = state_reg;
        commit     = 1'b0;
        do_read    = 1'b0;
        case (state_reg)
            IDLE, RD: begin
                if (we) begin
                    commit     = 1'b1;
                    state_next = WR_HOLD;
                end else if (oe) begin
                    do_read    = 1'b1;
                    state_next = RD;
                end else begin
                    state_next = IDLE;
                end
            end
            WR_HOLD: begin
                if (we) begin
                    state_next = WR_HOLD;
                end else if (oe) begin
                    do_read    = 1'b1;
                    state_next = RD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        read_entry = do_read && (state_reg != RD);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            always_ff @(posedge Clk) begin
                if (!Reset && commit && ram_hit && lane_en[gi]) begin
                    mem[idx] <= Data_from_CPU[gi*8 +: 8];
                end
            end
            assign ram_rd[gi*8 +: 8] = mem[idx];
        end
    endgenerate

    assign rd_src = ram_hit ? ram_rd : (io_hit ? Switches : 16'h0000);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            Data_to_CPU <= 16'h0000;
            Hex_Out     <= 16'h0000;
            Conflict    <= 1'b0;
        end else begin
            state_reg <= state_next;
            Conflict  <= commit & oe;
            if (do_read) begin
                Data_to_CPU <= rd_src & lane_mask;
            end
            if (commit && io_hit && !ram_hit) begin
                Hex_Out <= (Hex_Out & ~lane_mask) | (Data_from_CPU & lane_mask);
            end
        end
    end

`ifdef SRAM_RESPONDER_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Read_Count  <= 16'h0000;
            Write_Count <= 16'h0000;
        end else begin
            if (read_entry) Read_Count  <= Read_Count + 16'd1;
            if (commit)     Write_Count <= Write_Count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder; expected values flow through a scoreboard queue.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic        CE_N, OE_N, WE_N, UB_N, LB_N;
    logic [15:0] Switches;
    logic [15:0] Data_to_CPU;
    logic [15:0] Hex_Out;
    logic        Conflict;
`ifdef SRAM_RESPONDER_STATS_EN
    logic [15:0] Read_Count, Write_Count;
`endif

    sram_responder #(.ADDR_W(10), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N),
        .Switches(Switches), .Data_to_CPU(Data_to_CPU), .Hex_Out(Hex_Out),
        .Conflict(Conflict)
`ifdef SRAM_RESPONDER_STATS_EN
        , .Read_Count(Read_Count), .Write_Count(Write_Count)
`endif
    );

    always #5 Clk = ~Clk;

    logic [15:0] sb_q[$];
    int          checks = 0;
    int          passes = 0;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_val(input logic [15:0] exp);
        sb_q.push_back(exp);
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        exp = sb_q.pop_front();
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic release_bus();
        CE_N = 1'b1; OE_N = 1'b1; WE_N = 1'b1; UB_N = 1'b0; LB_N = 1'b0;
    endtask

    // WE_N low for two cycles; data changes in the hold cycle so a second commit would show.
    task automatic write_word(input logic [15:0] a, input logic [15:0] d, input logic ub, input logic lb);
        ADDR = a; Data_from_CPU = d; UB_N = ub; LB_N = lb; CE_N = 1'b0; WE_N = 1'b0;
        step();
        Data_from_CPU = ~d;
        step();
        release_bus();
        step();
    endtask

    // OE_N low for two cycles; data checked in the second OE-low cycle.
    task automatic read_check(input string tag, input logic [15:0] a, input logic ub, input logic lb,
                              input logic [15:0] exp);
        expect_val(exp);
        ADDR = a; UB_N = ub; LB_N = lb; CE_N = 1'b0; OE_N = 1'b0;
        step();
        check(tag, Data_to_CPU);
        step();
        release_bus();
        step();
    endtask

    initial begin
        Reset = 1'b1; ADDR = 16'h0; Data_from_CPU = 16'h0; Switches = 16'h0;
        release_bus();
        step(); step();
        expect_val(16'h0000); check("rst_data", Data_to_CPU);
        expect_val(16'h0000); check("rst_hex", Hex_Out);
        expect_val(16'h0000); check("rst_conflict", {15'h0, Conflict});
        Reset = 1'b0;
        step();

        write_word(16'h0010, 16'hBEEF, 1'b0, 1'b0);
        read_check("wr_rd", 16'h0010, 1'b0, 1'b0, 16'hBEEF);

        write_word(16'h0020, 16'h1234, 1'b0, 1'b0);
        write_word(16'h0020, 16'hABCD, 1'b1, 1'b0);
        read_check("lane_lo_wr", 16'h0020, 1'b0, 1'b0, 16'h12CD);
        read_check("lane_lo_rd", 16'h0020, 1'b0, 1'b1, 16'h1200);

        write_word(16'hFFFF, 16'h00F5, 1'b0, 1'b0);
        expect_val(16'h00F5); check("hex_write", Hex_Out);
        Switches = 16'h5A5A;
        read_check("switch_rd", 16'hFFFF, 1'b0, 1'b0, 16'h5A5A);
        write_word(16'h8000, 16'h9999, 1'b0, 1'b0);
        read_check("unmapped_rd", 16'h8000, 1'b0, 1'b0, 16'h0000);
        expect_val(16'h00F5); check("hex_hold", Hex_Out);

        // Conflict: write wins, read data untouched, one-cycle pulse
        read_check("pre_conflict", 16'hFFFF, 1'b0, 1'b0, 16'h5A5A);
        ADDR = 16'h0005; Data_from_CPU = 16'h7777; CE_N = 1'b0; OE_N = 1'b0; WE_N = 1'b0;
        step();
        expect_val(16'h0001); check("conflict_hi", {15'h0, Conflict});
        expect_val(16'h5A5A); check("conflict_data", Data_to_CPU);
        step();
        expect_val(16'h0000); check("conflict_lo", {15'h0, Conflict});
        release_bus();
        step();
        read_check("conflict_mem", 16'h0005, 1'b0, 1'b0, 16'h7777);

        // WR_HOLD -> RD with no idle cycle, then RD follows an address change
        ADDR = 16'h0040; Data_from_CPU = 16'h4444; CE_N = 1'b0; WE_N = 1'b0;
        step();
        WE_N = 1'b1; OE_N = 1'b0;
        step();
        expect_val(16'h4444); check("raw_b2b", Data_to_CPU);
        ADDR = 16'h0010;
        step();
        expect_val(16'hBEEF); check("rd_track", Data_to_CPU);
        // RD -> WR_HOLD directly
        ADDR = 16'h0041; Data_from_CPU = 16'h4141; OE_N = 1'b1; WE_N = 1'b0;
        step();
        release_bus();
        step();
        read_check("rd_to_wr", 16'h0041, 1'b0, 1'b0, 16'h4141);

        // CE_N rise while WE_N low is a release; next CE_N=0 commits again
        ADDR = 16'h0050; Data_from_CPU = 16'h5555; CE_N = 1'b0; WE_N = 1'b0;
        step();
        CE_N = 1'b1; Data_from_CPU = 16'h6666;
        step();
        CE_N = 1'b0;
        step();
        release_bus();
        step();
        read_check("ce_recommit", 16'h0050, 1'b0, 1'b0, 16'h6666);

        // Reset during the first WE_N-low cycle drops the write
        write_word(16'h0030, 16'h1111, 1'b0, 1'b0);
        read_check("pre_reset", 16'h0030, 1'b0, 1'b0, 16'h1111);
        ADDR = 16'h0030; Data_from_CPU = 16'h2222; CE_N = 1'b0; WE_N = 1'b0; Reset = 1'b1;
        step();
        expect_val(16'h0000); check("rst_mid_data", Data_to_CPU);
        expect_val(16'h0000); check("rst_mid_hex", Hex_Out);
        Reset = 1'b0;
        release_bus();
        step();
        read_check("rst_mid_mem", 16'h0030, 1'b0, 1'b0, 16'h1111);

`ifdef SRAM_RESPONDER_STATS_EN
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        write_word(16'h0060, 16'h0001, 1'b0, 1'b0);
        write_word(16'h0061, 16'h0002, 1'b0, 1'b0);
        write_word(16'hFFFF, 16'h0003, 1'b0, 1'b0);
        read_check("stat_rd0", 16'h0060, 1'b0, 1'b0, 16'h0001);
        read_check("stat_rd1", 16'h0061, 1'b0, 1'b0, 16'h0002);
        expect_val(16'd3); check("write_count", Write_Count);
        expect_val(16'd2); check("read_count", Read_Count);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
